// File: rtl/bcd2bin_seq_pkg.sv
// bcd2bin_seq_pkg: shared FSM encoding, BCD limit and index-width helper
package bcd2bin_seq_pkg;
    typedef enum logic {ST_IDLE = 1'b0, ST_CONV = 1'b1} state_t;
    localparam logic [3:0] BCD_MAX = 4'd9;
    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) if ((1 << i) < n) r = i + 1;
        return r;
    endfunction
endpackage

// File: rtl/bcd2bin_seq_mac10.sv
// bcd_mac10: saturating one-digit step acc*10 + d, flags digits above 9
module bcd_mac10
    import bcd2bin_seq_pkg::*;
#(
    parameter int BIN_W = 10
) (
    input  logic [BIN_W-1:0] acc_in,
    input  logic [3:0]       digit,
    output logic [BIN_W-1:0] acc_out,
    output logic             digit_bad
);
    logic [3:0] d;
    assign digit_bad = digit > BCD_MAX;
    assign d = digit_bad ? BCD_MAX : digit;
    // Truncation mod 2**BIN_W makes BIN_W-wide arithmetic equal to the wider sum
    assign acc_out = (acc_in << 3) + (acc_in << 1) + {{(BIN_W-4){1'b0}}, d};
endmodule

// File: rtl/bcd2bin_seq.sv
// bcd2bin_seq: sequential packed-BCD to binary converter, one digit per clock, MSD first
module bcd2bin_seq
    import bcd2bin_seq_pkg::*;
#(
    parameter int DIGITS = 3,
    parameter int BIN_W  = 10
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [4*DIGITS-1:0]   bcd,
    output logic [BIN_W-1:0]      bin,
    output logic                  busy,
    output logic                  done,
    output logic                  err
);
    localparam int IDX_W = (clog2(DIGITS) < 1) ? 1 : clog2(DIGITS);

    if (DIGITS < 1 || (BIN_W < 31 && (1 << BIN_W) <= 10**DIGITS - 1)) begin : g_width_err
        $error("bcd2bin_seq: BIN_W too small for DIGITS");
    end

    state_t              state, state_nxt;
    logic [4*DIGITS-1:0] lat;
    logic [BIN_W-1:0]    acc, nxt;
    logic [IDX_W-1:0]    idx;
    logic                err_acc, bad;
    logic [3:0]          cur;

    assign cur = lat[{idx, 2'b00} +: 4];

    bcd_mac10 #(.BIN_W(BIN_W)) u_mac (
        .acc_in   (acc),
        .digit    (cur),
        .acc_out  (nxt),
        .digit_bad(bad)
    );

    always_comb begin
        state_nxt = (state == ST_IDLE) ? (start ? ST_CONV : ST_IDLE)
                                       : ((idx == '0) ? ST_IDLE : ST_CONV);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ST_IDLE;
            lat     <= '0;
            acc     <= '0;
            idx     <= '0;
            err_acc <= 1'b0;
            bin     <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            err     <= 1'b0;
        end else begin
            state <= state_nxt;
            done  <= 1'b0;
            // busy covers every CONV cycle except the one that produces done
            busy  <= (state == ST_CONV) && (idx != '0);
            if (state == ST_IDLE) begin
                if (start) begin
                    lat     <= bcd;
                    acc     <= '0;
                    idx     <= IDX_W'(DIGITS - 1);
                    err_acc <= 1'b0;
                end
            end else if (idx != '0) begin
                acc     <= nxt;
                idx     <= idx - 1'b1;
                err_acc <= err_acc | bad;
            end else begin
                bin  <= nxt;
                err  <= err_acc | bad;
                done <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_bcd2bin_seq.sv
// tb_bcd2bin_seq: directed and randomized checks of bcd2bin_seq against a decimal model
module tb_bcd2bin_seq;
    localparam int DIGITS = 3;
    localparam int BIN_W  = 10;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              start = 1'b1;
    logic [11:0]       bcd = 12'h999;
    logic [BIN_W-1:0]  bin;
    logic              busy, done, err;
    int                checks = 0;
    int                failures = 0;

    bcd2bin_seq #(.DIGITS(DIGITS), .BIN_W(BIN_W)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .start(start),
        .bcd  (bcd),
        .bin  (bin),
        .busy (busy),
        .done (done),
        .err  (err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Decimal value of the digits with anything above 9 treated as 9
    function automatic int model(input logic [11:0] b, output bit e);
        int v, d;
        v = 0;
        e = 1'b0;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            d = int'(b[4*i +: 4]);
            if (d > 9) begin
                d = 9;
                e = 1'b1;
            end
            v = v * 10 + d;
        end
        return v;
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_idle_zero(input string tag);
        chk({tag, "_bin"}, bin, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_err"}, err, 0);
    endtask

    task automatic convert(input logic [11:0] v, input bit hazard);
        int ev;
        bit ee;
        ev = model(v, ee);
        bcd = v;
        start = 1'b1;
        tick;
        start = 1'b0;
        chk("accept_busy", busy, 0);
        chk("accept_done", done, 0);
        for (int k = 1; k < DIGITS; k++) begin
            if (hazard) begin
                start = (k == 1);
                bcd = 12'($urandom);
            end
            tick;
            start = 1'b0;
            chk("conv_busy", busy, 1);
            chk("conv_done", done, 0);
        end
        tick;
        chk("done_pulse", done, 1);
        chk("done_busy", busy, 0);
        chk("done_bin", bin, 32'(ev));
        chk("done_err", err, 32'(ee));
        tick;
        chk("after_done", done, 0);
        chk("hold_bin", bin, 32'(ev));
        chk("hold_err", err, 32'(ee));
    endtask

    initial begin
        for (int c = 0; c < 4; c++) begin
            tick;
            chk_idle_zero("reset");
        end
        rst_n = 1'b1;
        start = 1'b0;
        tick;
        chk_idle_zero("post_reset");

        convert(12'h255, 1'b0);
        convert(12'h000, 1'b0);
        convert(12'h999, 1'b0);
        convert(12'h010, 1'b0);
        convert(12'h1A3, 1'b0);
        convert(12'h042, 1'b0);
        convert(12'h123, 1'b1);

        // start held high: second conversion accepted in the done cycle of the first
        bcd = 12'h123;
        start = 1'b1;
        tick;
        bcd = 12'h456;
        for (int cyc = 1; cyc <= 8; cyc++) begin
            tick;
            chk("b2b_done", done, 32'(cyc == 3 || cyc == 7));
            if (cyc == 3) chk("b2b_bin1", bin, 123);
            if (cyc == 7) chk("b2b_bin2", bin, 456);
            if (cyc == 4) start = 1'b0;
        end

        bcd = 12'h777;
        start = 1'b1;
        tick;
        start = 1'b0;
        tick;
        rst_n = 1'b0;
        #1;
        chk_idle_zero("abort");
        tick;
        chk_idle_zero("abort_hold");
        rst_n = 1'b1;
        for (int c = 0; c < 4; c++) begin
            tick;
            chk("abort_no_done", done, 0);
            chk("abort_bin", bin, 0);
        end
        convert(12'h321, 1'b0);

        for (int n = 0; n < 24; n++) convert(12'($urandom), 1'($urandom_range(0, 1)));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
